// File: rtl/sample_fifo_if.sv
// Capture-to-readout FIFO bus: write/read requests and clear from the master, data and status back from the FIFO.
interface sample_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             clear;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [LW-1:0]    level;
  logic             overflow;

  modport master (
    output clear, wr_data, wr_en, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, level, overflow
  );

  modport slave (
    input  clear, wr_data, wr_en, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, level, overflow
  );
endinterface

// File: rtl/sample_fifo.sv
// Circular-buffer sample FIFO; popped word appears on rd_data with a 1-cycle rd_valid one clock after rd_ok.
// No stall: writes to a full FIFO are dropped (sticky overflow) unless paired with a read; reads when empty are ignored.
module sample_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  sample_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  // clear masks both requests so neither storage nor pointers move that cycle
  assign w_rd_ok = bus.rd_en && !w_empty && !bus.clear;
  assign w_wr_ok = bus.wr_en && (!w_full || w_rd_ok) && !bus.clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (bus.wr_en && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almost_full = (r_level >= LW'(AF_THRESH));
  assign bus.level       = r_level;
  assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo: reference queue model plus expected-read scoreboard, checked every cycle.
module tb_sample_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic clk;
  logic rst_n;

  sample_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level",       32'(bus.level),    32'(m_q.size()));
    chk("empty",       32'(bus.empty),    32'(m_q.size() == 0));
    chk("full",        32'(bus.full),     32'(m_q.size() == DEPTH));
    chk("almost_full", 32'(bus.almost_full), 32'(m_q.size() >= AF));
    chk("overflow",    32'(bus.overflow), 32'(m_ovf));
    chk("rd_valid",    32'(bus.rd_valid), 32'(m_valid));
    chk("rd_data",     32'(bus.rd_data),  32'(m_data));
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock of stimulus; the model predicts from pre-edge state, compares at posedge+1
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    bit rd_ok;
    bit wr_ok;
    int n;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.clear   = clr;
    n     = m_q.size();
    rd_ok = re && (n != 0) && !clr;
    wr_ok = we && ((n < DEPTH) || rd_ok) && !clr;
    @(posedge clk);
    #1;
    if (clr) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_valid = 1'b0;
    end else begin
      m_valid = rd_ok;
      if (rd_ok) exp_q.push_back(m_q.pop_front());
      if (wr_ok) m_q.push_back(wd);
      if (we && !wr_ok) m_ovf = 1'b1;
    end
    if (m_valid && exp_q.size() > 0) m_data = exp_q.pop_front();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clear = 1'b0;
    check_all();
  endtask

  initial begin
    bus.clear   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    rst_n       = 1'b0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fill to full
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);

    // dropped write, sticky overflow, drain in order
    step(1, 8'h55, 0, 0);
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);

    // wrap-around with level capped at 2
    for (int i = 0; i < 10; i++) step(1, 8'(i), (i >= 2), 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // full plus simultaneous read/write
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 0);
    step(1, 8'hAA, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

    // empty plus simultaneous read/write: no fall-through
    step(1, 8'h77, 1, 0);
    step(0, 8'h00, 1, 0);

    // clear with level 3, overflow set, requests high
    for (int i = 0; i < 4; i++) step(1, 8'hC0 + 8'(i), 0, 0);
    step(1, 8'hCF, 0, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'hD0, 1, 1);
    step(1, 8'hE1, 0, 0);
    step(1, 8'hE2, 0, 0);
    step(0, 8'h00, 1, 0);

    // asynchronous reset in the middle of a write cycle
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hF0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    bus.wr_en = 1'b0;
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 8'h00, 1, 0);
    step(1, 8'h3C, 0, 0);
    step(0, 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
